// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with a frame counter that pulses done once every WIDTH shifts.
module univ_shift_reg #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             serInL,
   input  logic             serInR,
   input  logic [WIDTH-1:0] PI,
   output logic [WIDTH-1:0] PO,
   output logic             serOutR,
   output logic             serOutL,
   output logic [CW-1:0]    cnt,
   output logic             done
);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic shift_any;

   assign shift_any = en && ((mode == MODE_RIGHT) || (mode == MODE_LEFT));

   assign serOutR = PO[0];
   assign serOutL = PO[WIDTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PO <= '0;
      end else if (en) begin
         case (mode)
            MODE_RIGHT: PO <= {serInL, PO[WIDTH-1:1]};
            MODE_LEFT:  PO <= {PO[WIDTH-2:0], serInR};
            MODE_LOAD:  PO <= PI;
            default:    PO <= PO;
         endcase
      end
   end

   // Shifts in either direction advance the frame; a load aborts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (shift_any) begin
            if (cnt == CNT_LAST) begin
               cnt  <= '0;
               done <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else if (en && (mode == MODE_LOAD)) begin
            cnt <= '0;
         end
      end
   end

endmodule
